// File: rtl/scan_pkg.sv
// Shared types for the configuration scan-chain loader: FSM states and op codes.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } scan_state_t;

  localparam logic SCAN_OP_LOAD = 1'b0;
  localparam logic SCAN_OP_READ = 1'b1;

endpackage

// File: rtl/scan_chain_loader.sv
// Serialises a parallel config word LSB-first into a scan chain and captures the
// previous chain contents as a readback word; READ recirculates the chain unchanged.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_op,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  output logic                 se,
  output logic                 si,
  input  logic                 so_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rdbk_data
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);

  scan_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] rdbk_q, rdbk_d;
  logic                 op_q, op_d;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_q     <= '0;
      shadow_q <= '0;
      rdbk_q   <= '0;
      op_q     <= SCAN_OP_LOAD;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      shadow_q <= shadow_d;
      rdbk_q   <= rdbk_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    shadow_d = shadow_q;
    rdbk_d   = rdbk_q;
    op_d     = op_q;
    accept   = cfg_valid && (state_q != SHIFT);

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          tx_d    = cfg_data;
          op_d    = cfg_op;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Tail bits arrive oldest-first, so they enter at the MSB and walk down to bit 0.
        shadow_d = {so_in, shadow_q[CHAIN_LEN-1:1]};
        tx_d     = {1'b0, tx_q[CHAIN_LEN-1:1]};
        if (cnt_q != FULL_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_q == LAST_CNT) begin
          rdbk_d  = shadow_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign se        = (state_q == SHIFT);
  assign busy      = se;
  assign done      = (state_q == DONE);
  assign cfg_ready = !se;
  // READ feeds the tail straight back into the head so the chain rotates to its start.
  assign si        = se && ((op_q == SCAN_OP_READ) ? so_in : tx_q[0]);
  assign rdbk_data = rdbk_q;

endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: 8-bit and 64-bit instances each driving a model scan chain.
module tb_scan_chain_loader;
  import scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       v8, op8, rdy8, se8, si8, so8, busy8, done8;
  logic [7:0] d8, rd8;
  logic [7:0] chain8 = '0;

  logic        v64, op64, rdy64, se64, si64, so64, busy64, done64;
  logic [63:0] d64, rd64;
  logic [63:0] chain64 = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] rdbk;
    logic [63:0] chain;
  } exp_t;

  exp_t exp8[$];
  exp_t exp64[$];
  int   acc8[$];
  int   acc64[$];
  int   secnt8 = 0;
  int   secnt64 = 0;
  exp_t e8, e64;
  int   a8, a64;

  scan_chain_loader #(.CHAIN_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .cfg_valid(v8), .cfg_ready(rdy8), .cfg_op(op8),
    .cfg_data(d8), .se(se8), .si(si8), .so_in(so8), .busy(busy8), .done(done8),
    .rdbk_data(rd8)
  );

  scan_chain_loader #(.CHAIN_LEN(64)) dut64 (
    .clk(clk), .reset(reset), .cfg_valid(v64), .cfg_ready(rdy64), .cfg_op(op64),
    .cfg_data(d64), .se(se64), .si(si64), .so_in(so64), .busy(busy64), .done(done64),
    .rdbk_data(rd64)
  );

  // Model chains: head is flop N-1, tail is flop 0.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (se8)  chain8  <= {si8, chain8[7:1]};
  always @(posedge clk) if (se64) chain64 <= {si64, chain64[63:1]};
  assign so8  = chain8[0];
  assign so64 = chain64[0];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Scoreboard monitor, 8-bit instance
  always @(negedge clk) begin
    if (!reset) begin
      exp8.delete();
      acc8.delete();
      secnt8 = 0;
    end else begin
      if (se8) secnt8++;
      if (done8) begin
        if (exp8.size() == 0 || acc8.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done8_unexpected: got done=1 expected no pending op");
        end else begin
          e8 = exp8.pop_front();
          a8 = acc8.pop_front();
          chk("rdbk8", 64'(rd8), e8.rdbk);
          chk("chain8", 64'(chain8), e8.chain);
          chk("latency8", 64'(cyc - a8), 64'd9);
          chk("se_cycles8", 64'(secnt8), 64'd8);
          $display("op8 done: rdbk=%h chain=%h latency=%0d", rd8, chain8, cyc - a8);
        end
        secnt8 = 0;
      end
      if (v8 && rdy8) acc8.push_back(cyc);
    end
  end

  // Scoreboard monitor, 64-bit instance
  always @(negedge clk) begin
    if (!reset) begin
      exp64.delete();
      acc64.delete();
      secnt64 = 0;
    end else begin
      if (se64) secnt64++;
      if (done64) begin
        if (exp64.size() == 0 || acc64.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL done64_unexpected: got done=1 expected no pending op");
        end else begin
          e64 = exp64.pop_front();
          a64 = acc64.pop_front();
          chk("rdbk64", rd64, e64.rdbk);
          chk("chain64", chain64, e64.chain);
          chk("latency64", 64'(cyc - a64), 64'd65);
          chk("se_cycles64", 64'(secnt64), 64'd64);
          $display("op64 done: rdbk=%h chain=%h latency=%0d", rd64, chain64, cyc - a64);
        end
        secnt64 = 0;
      end
      if (v64 && rdy64) acc64.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic op, input logic [7:0] d, input logic [7:0] er,
                        input logic [7:0] ec);
    exp8.push_back('{64'(er), 64'(ec)});
    v8 = 1'b1; op8 = op; d8 = d;
    tick();
    v8 = 1'b0;
  endtask

  task automatic start64(input logic op, input logic [63:0] d, input logic [63:0] er,
                         input logic [63:0] ec);
    exp64.push_back('{er, ec});
    v64 = 1'b1; op64 = op; d64 = d;
    tick();
    v64 = 1'b0;
  endtask

  task automatic wait_done8();
    int k = 0;
    while (!done8 && k < 100) begin tick(); k++; end
    if (!done8) begin
      n_cmp++; n_err++;
      $display("FAIL timeout8: got no done within 100 cycles expected done");
    end
  endtask

  task automatic wait_done64();
    int k = 0;
    while (!done64 && k < 200) begin tick(); k++; end
    if (!done64) begin
      n_cmp++; n_err++;
      $display("FAIL timeout64: got no done within 200 cycles expected done");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    pat = 8'hA5;
    reset = 1'b0;
    v8 = 1'b0; op8 = SCAN_OP_LOAD; d8 = '0;
    v64 = 1'b0; op64 = SCAN_OP_LOAD; d64 = '0;
    repeat (3) tick();
    chk("rst_se", 64'(se8), 64'd0);
    chk("rst_si", 64'(si8), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_ready", 64'(rdy8), 64'd1);
    chk("rst_rdbk", 64'(rd8), 64'd0);
    reset = 1'b1;
    tick();

    // LOAD 0xA5 into an all-zero chain; watch the serial stream
    start8(SCAN_OP_LOAD, 8'hA5, 8'h00, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      chk("a5_si_bit", 64'(si8), 64'(pat[i]));
      chk("a5_se", 64'(se8), 64'd1);
      tick();
    end
    wait_done8();
    chk("done_si_low", 64'(si8), 64'd0);
    tick();

    // READ must preserve the chain, then LOAD 0x3C
    start8(SCAN_OP_READ, 8'hFF, 8'hA5, 8'hA5);
    wait_done8();
    tick();
    start8(SCAN_OP_LOAD, 8'h3C, 8'hA5, 8'h3C);
    wait_done8();
    tick();

    // Back-to-back with cfg_valid held; data changes after acceptance
    exp8.push_back('{64'h3C, 64'h0F});
    exp8.push_back('{64'h0F, 64'hF0});
    v8 = 1'b1; op8 = SCAN_OP_LOAD; d8 = 8'h0F;
    tick();
    d8 = 8'hF0;
    wait_done8();
    chk("b2b_gap_se_low", 64'(se8), 64'd0);
    tick();
    chk("b2b_se_high_after_one", 64'(se8), 64'd1);
    chk("b2b_done_one_cycle", 64'(done8), 64'd0);
    v8 = 1'b0;
    wait_done8();
    tick();

    // Junk handshakes during SHIFT are ignored
    start8(SCAN_OP_LOAD, 8'h5A, 8'hF0, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      v8 = (i % 2 == 1);
      d8 = 8'(i * 37 + 1);
      op8 = SCAN_OP_READ;
      chk("shift_ready_low", 64'(rdy8), 64'd0);
      chk("shift_busy", 64'(busy8), 64'd1);
      tick();
    end
    v8 = 1'b0;
    wait_done8();
    tick();

    // Reset after 3 shifts; the 4th edge still shifts 0x5A -> 0x15
    v8 = 1'b1; op8 = SCAN_OP_LOAD; d8 = 8'h81;
    tick();
    v8 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("midrst_se", 64'(se8), 64'd0);
    chk("midrst_busy", 64'(busy8), 64'd0);
    chk("midrst_done", 64'(done8), 64'd0);
    chk("midrst_ready", 64'(rdy8), 64'd1);
    chk("midrst_rdbk", 64'(rd8), 64'd0);
    reset = 1'b1;
    tick();
    start8(SCAN_OP_LOAD, 8'h81, 8'h15, 8'h81);
    wait_done8();
    tick();

    // 64-bit chain
    start64(SCAN_OP_LOAD, 64'hDEADBEEF_01234567, 64'd0, 64'hDEADBEEF_01234567);
    wait_done64();
    tick();
    start64(SCAN_OP_READ, 64'h0, 64'hDEADBEEF_01234567, 64'hDEADBEEF_01234567);
    wait_done64();
    tick();

    repeat (3) tick();
    chk("pending8", 64'(exp8.size()), 64'd0);
    chk("pending64", 64'(exp64.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
